// File: rtl/hw_stack_unit_if.sv
// Control/data bundle between the core's decode/writeback and hw_stack_unit.
// master = core side (drives ops), slave = stack unit.
interface hw_stack_unit_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              push;
   logic              pop;
   logic              flush;
   logic              err_clr;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] top_data;
   logic [ADDR_W-1:0] sp;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              ovf;
   logic              unf;

   modport master (
      output push, pop, flush, err_clr, push_data,
      input  top_data, sp, count, empty, full, ovf, unf
   );

   modport slave (
      input  push, pop, flush, err_clr, push_data,
      output top_data, sp, count, empty, full, ovf, unf
   );
endinterface

// File: rtl/hw_stack_unit.sv
// Downward-growing hardware LIFO with overflow/underflow guarding; state moves on negedge clk.
// Define STACK_ERR_STICKY_EN to make ovf/unf sticky flags cleared by err_clr.
module hw_stack_unit #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter int                DEPTH    = 16,
   parameter logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(8'hFF)
) (
   input logic             clk,
   input logic             rst,
   hw_stack_unit_if.slave  stk
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  top_idx;
   logic              is_empty;
   logic              is_full;
   logic              ovf_evt;
   logic              unf_evt;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == CNT_W'(DEPTH));
   assign top_idx  = IDX_W'(count_reg - CNT_W'(1));

   always_comb begin
      count_next = count_reg;
      wr_en      = 1'b0;
      wr_idx     = IDX_W'(count_reg);
      ovf_evt    = 1'b0;
      unf_evt    = 1'b0;
      if (stk.flush) begin
         count_next = '0;
      end else if (stk.push && stk.pop) begin
         wr_en = 1'b1;
         if (is_empty) begin
            // Push&pop on an empty stack degenerates to a plain push.
            count_next = count_reg + CNT_W'(1);
         end else begin
            wr_idx = top_idx;
         end
      end else if (stk.push) begin
         if (is_full) begin
            ovf_evt = 1'b1;
         end else begin
            wr_en      = 1'b1;
            count_next = count_reg + CNT_W'(1);
         end
      end else if (stk.pop) begin
         if (is_empty) begin
            unf_evt = 1'b1;
         end else begin
            count_next = count_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(negedge clk) begin
      if (!rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // Storage is never cleared; an empty stack masks it on the read side.
   always_ff @(negedge clk) begin
      if (rst && wr_en) begin
         mem[wr_idx] <= stk.push_data;
      end
   end

   assign stk.top_data = is_empty ? '0 : mem[top_idx];
   assign stk.sp       = TOP_ADDR - ADDR_W'(count_reg);
   assign stk.count    = count_reg;
   assign stk.empty    = is_empty;
   assign stk.full     = is_full;

`ifdef STACK_ERR_STICKY_EN
   logic ovf_reg;
   logic unf_reg;

   // A new event at the same edge as err_clr keeps the flag set.
   always_ff @(negedge clk) begin
      if (!rst) begin
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else begin
         if (ovf_evt)          ovf_reg <= 1'b1;
         else if (stk.err_clr) ovf_reg <= 1'b0;
         if (unf_evt)          unf_reg <= 1'b1;
         else if (stk.err_clr) unf_reg <= 1'b0;
      end
   end

   assign stk.ovf = ovf_reg;
   assign stk.unf = unf_reg;
`else
   logic unused_err_clr;

   assign unused_err_clr = stk.err_clr;
   assign stk.ovf        = ovf_evt & rst;
   assign stk.unf        = unf_evt & rst;
`endif
endmodule

// File: tb/tb_hw_stack_unit.sv
// Directed bench for hw_stack_unit (DEPTH=16, TOP_ADDR=8'hFF); works with or without
// STACK_ERR_STICKY_EN defined.
module tb_hw_stack_unit;
   logic clk = 1'b1;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   hw_stack_unit_if #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) bus ();

   hw_stack_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .TOP_ADDR(8'hFF)) u_dut (
      .clk (clk),
      .rst (rst),
      .stk (bus)
   );

   always #5 clk = ~clk;

`ifdef STACK_ERR_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
      $display("check %-12s observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
   endtask

   task automatic do_push(input logic [7:0] d);
      bus.push = 1'b1; bus.push_data = d;
      cycle();
      idle();
   endtask

   task automatic do_pop();
      bus.pop = 1'b1;
      cycle();
      idle();
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      cycle();
      idle();
   endtask

   initial begin
      bus.push_data = 8'h00;
      idle();
      // 1. reset
      cycle(); cycle();
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_sp",    32'(bus.sp), 32'hFF);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full",  32'(bus.full), 0);
      chk("rst_top",   32'(bus.top_data), 0);
      chk("rst_ovf",   32'(bus.ovf), 0);
      chk("rst_unf",   32'(bus.unf), 0);
      rst = 1'b1;

      // 2. push three, pop two
      do_push(8'hA1); do_push(8'hB2); do_push(8'hC3);
      chk("p3_sp",    32'(bus.sp), 32'hFC);
      chk("p3_count", 32'(bus.count), 3);
      chk("p3_top",   32'(bus.top_data), 32'hC3);
      do_pop(); do_pop();
      chk("pop2_top", 32'(bus.top_data), 32'hA1);
      chk("pop2_sp",  32'(bus.sp), 32'hFE);
      do_pop();
      chk("pop3_empty", 32'(bus.empty), 1);

      // 3. fill to DEPTH, then overflow
      for (int i = 0; i < 16; i++) do_push(8'(8'h30 + i));
      chk("fill_full",  32'(bus.full), 1);
      chk("fill_empty", 32'(bus.empty), 0);
      chk("fill_sp",    32'(bus.sp), 32'hEF);
      chk("fill_top",   32'(bus.top_data), 32'h3F);
      bus.push = 1'b1; bus.push_data = 8'h55;
      cycle();
      chk("ovf_count", 32'(bus.count), 16);
      chk("ovf_sp",    32'(bus.sp), 32'hEF);
      chk("ovf_top",   32'(bus.top_data), 32'h3F);
      chk("ovf_flag",  32'(bus.ovf), 1);
      idle(); #1;
      chk("ovf_after", 32'(bus.ovf), 32'(STICKY));
      cycle();
      chk("ovf_hold",  32'(bus.ovf), 32'(STICKY));
      bus.push = 1'b1; bus.err_clr = 1'b1;
      cycle();
      chk("ovf_setwin", 32'(bus.ovf), 1);
      idle();
      bus.err_clr = 1'b1;
      cycle();
      idle();
      chk("ovf_clr",   32'(bus.ovf), 0);

      // 4. underflow, then push&pop on empty
      do_flush();
      chk("fl_count", 32'(bus.count), 0);
      chk("fl_ovf",   32'(bus.ovf), 0);
      bus.pop = 1'b1;
      cycle();
      chk("unf_sp",    32'(bus.sp), 32'hFF);
      chk("unf_count", 32'(bus.count), 0);
      chk("unf_flag",  32'(bus.unf), 1);
      idle(); #1;
      chk("unf_after", 32'(bus.unf), 32'(STICKY));
      bus.err_clr = 1'b1;
      cycle();
      idle();
      chk("unf_clr",   32'(bus.unf), 0);
      bus.push = 1'b1; bus.pop = 1'b1; bus.push_data = 8'h77;
      cycle();
      chk("pp0_count", 32'(bus.count), 1);
      chk("pp0_top",   32'(bus.top_data), 32'h77);
      chk("pp0_unf",   32'(bus.unf), 0);
      idle();

      // 5. replace top
      do_flush();
      do_push(8'h10); do_push(8'h20);
      bus.push = 1'b1; bus.pop = 1'b1; bus.push_data = 8'h99;
      cycle();
      idle();
      chk("rep_count", 32'(bus.count), 2);
      chk("rep_top",   32'(bus.top_data), 32'h99);
      do_pop();
      chk("rep_pop",   32'(bus.top_data), 32'h10);

      // 6. flush priority, then reset mid-fill
      do_flush();
      for (int i = 0; i < 5; i++) do_push(8'(8'h60 + i));
      chk("f5_count", 32'(bus.count), 5);
      bus.flush = 1'b1; bus.push = 1'b1; bus.push_data = 8'hEE;
      cycle();
      idle();
      chk("fp_count", 32'(bus.count), 0);
      chk("fp_empty", 32'(bus.empty), 1);
      chk("fp_top",   32'(bus.top_data), 0);
      do_push(8'h01); do_push(8'h02); do_push(8'h03);
      chk("mf_sp", 32'(bus.sp), 32'hFC);
      rst = 1'b0; bus.push = 1'b1; bus.push_data = 8'h04;
      cycle();
      chk("mr_sp",    32'(bus.sp), 32'hFF);
      chk("mr_count", 32'(bus.count), 0);
      chk("mr_empty", 32'(bus.empty), 1);
      chk("mr_top",   32'(bus.top_data), 0);
      idle();
      rst = 1'b1;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
